// File: rtl/pc_fetch.sv
// pc_fetch: holds the program counter, fetches one instruction at a time and
// commits it to the next PC chosen by the branch/jump select, halting on a misaligned target.
module pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  npc_op,
    input  logic [31:0] imm,
    input  logic [31:0] alu_c,
    input  logic        zero,
    input  logic        sgn,
    input  logic        ex_valid,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic        misalign,
    output logic [31:0] instret
);
    typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

    localparam logic [2:0] OP_BEQ  = 3'b001;
    localparam logic [2:0] OP_BNE  = 3'b010;
    localparam logic [2:0] OP_BLT  = 3'b011;
    localparam logic [2:0] OP_BGE  = 3'b100;
    localparam logic [2:0] OP_JAL  = 3'b101;
    localparam logic [2:0] OP_JALR = 3'b110;

    state_t      state, state_nxt;
    logic        take, commit, aligned;
    logic [31:0] npc;

    assign pc4        = pc + 32'd4;
    assign imem_req   = state == FETCH;
    assign imem_addr  = pc;
    assign inst_valid = state == EXEC;
    assign commit     = state == EXEC && ex_valid;
    assign aligned    = npc[1:0] == 2'b00;

    always_comb begin
        take = npc_op == OP_BEQ ? zero :
               npc_op == OP_BNE ? !zero :
               npc_op == OP_BLT ? sgn :
               npc_op == OP_BGE ? !sgn :
               npc_op == OP_JAL;
        npc  = npc_op == OP_JALR ? {alu_c[31:1], 1'b0} : take ? pc + imm : pc4;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = FETCH;
            FETCH:   state_nxt = imem_ack ? EXEC : FETCH;
            EXEC:    state_nxt = !commit ? EXEC : aligned ? FETCH : HALT;
            default: state_nxt = HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            inst     <= '0;
            misalign <= 1'b0;
            instret  <= '0;
        end else begin
            if (state == FETCH && imem_ack) inst <= imem_rdata;
            // a misaligned target leaves pc on the faulting instruction
            if (commit && aligned) begin
                pc      <= npc;
                instret <= instret + 32'd1;
            end
            if (commit && !aligned) misalign <= 1'b1;
        end
    end
endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: directed and randomized fetch/commit sequences checked against
// a transaction-level next-PC model.
module tb_pc_fetch;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  npc_op = 3'd0;
    logic [31:0] imm = '0, alu_c = '0, imem_rdata = '0;
    logic        zero = 1'b0, sgn = 1'b0, ex_valid = 1'b0, imem_ack = 1'b0;
    logic        imem_req, inst_valid, misalign;
    logic [31:0] imem_addr, inst, pc, pc4, instret;

    int          errors = 0, checks = 0;
    logic [31:0] exp_pc, exp_ret, exp_inst;
    logic        halted;

    pc_fetch #(.RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .npc_op(npc_op), .imm(imm), .alu_c(alu_c),
        .zero(zero), .sgn(sgn), .ex_valid(ex_valid), .imem_req(imem_req),
        .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .inst(inst), .inst_valid(inst_valid), .pc(pc), .pc4(pc4),
        .misalign(misalign), .instret(instret)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_npc(input logic [2:0] op, input logic [31:0] p, i, a,
                                             input logic z, s);
        logic [31:0] seq, tgt;
        seq = p + 32'd4;
        tgt = p + i;
        case (op)
            3'd1:    return z ? tgt : seq;
            3'd2:    return z ? seq : tgt;
            3'd3:    return s ? tgt : seq;
            3'd4:    return s ? seq : tgt;
            3'd5:    return tgt;
            3'd6:    return a & 32'hFFFF_FFFE;
            default: return seq;
        endcase
    endfunction

    // asserts reset mid-cycle, then leaves the bench at a negedge in FETCH
    task automatic do_reset();
        #2 rst_n = 1'b0;
        imem_ack = 1'b1;
        ex_valid = 1'b1;
        #1;
        check("rst_req", imem_req, 0);
        check("rst_ivalid", inst_valid, 0);
        check("rst_inst", inst, 0);
        check("rst_pc", pc, 0);
        check("rst_addr", imem_addr, 0);
        check("rst_mis", misalign, 0);
        check("rst_ret", instret, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check("idle_req", imem_req, 0);
        check("idle_ivalid", inst_valid, 0);
        @(negedge clk);
        exp_pc = 32'h0;
        exp_ret = 0;
        halted = 1'b0;
    endtask

    task automatic fetch(input int wait_n, input logic [31:0] word);
        ex_valid = 1'b1;
        for (int i = 0; i < wait_n; i++) begin
            check("f_req", imem_req, 1);
            check("f_addr", imem_addr, exp_pc);
            imem_ack = 1'b0;
            imem_rdata = $urandom;
            @(negedge clk);
        end
        check("f_req", imem_req, 1);
        check("f_addr", imem_addr, exp_pc);
        check("f_ivalid", inst_valid, 0);
        imem_ack = 1'b1;
        imem_rdata = word;
        exp_inst = word;
        @(negedge clk);
        imem_ack = 1'b0;
        imem_rdata = $urandom;
    endtask

    task automatic exec(input logic [2:0] op, input logic [31:0] i, a, input logic z, s,
                        input int stall);
        logic [31:0] n;
        for (int k = 0; k < stall; k++) begin
            ex_valid = 1'b0;
            imem_ack = 1'($urandom);
            check("e_ivalid", inst_valid, 1);
            check("e_req", imem_req, 0);
            check("e_inst", inst, exp_inst);
            check("e_pc", pc, exp_pc);
            check("e_pc4", pc4, exp_pc + 32'd4);
            check("e_addr", imem_addr, exp_pc);
            @(negedge clk);
        end
        check("e_ivalid", inst_valid, 1);
        check("e_inst", inst, exp_inst);
        npc_op = op; imm = i; alu_c = a; zero = z; sgn = s;
        ex_valid = 1'b1;
        imem_ack = 1'b0;
        @(negedge clk);
        n = ref_npc(op, exp_pc, i, a, z, s);
        if (n[1:0] == 2'b00) begin
            exp_pc = n;
            exp_ret = exp_ret + 32'd1;
        end else begin
            halted = 1'b1;
        end
        check("c_pc", pc, exp_pc);
        check("c_ret", instret, exp_ret);
        check("c_mis", misalign, 32'(halted));
        check("c_req", imem_req, 32'(!halted));
        check("c_ivalid", inst_valid, 0);
    endtask

    task automatic halt_check(input int n);
        for (int k = 0; k < n; k++) begin
            imem_ack = 1'b1;
            ex_valid = 1'b1;
            npc_op = 3'd0;
            @(negedge clk);
            check("h_req", imem_req, 0);
            check("h_ivalid", inst_valid, 0);
            check("h_mis", misalign, 1);
            check("h_pc", pc, exp_pc);
            check("h_addr", imem_addr, exp_pc);
            check("h_ret", instret, exp_ret);
        end
    endtask

    initial begin
        logic [31:0] ri, ra;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            fetch(0, 32'h0000_0013 + k);
            exec(3'd0, $urandom, $urandom, 1'($urandom), 1'($urandom), 0);
        end
        fetch(0, 32'h1111_1111); exec(3'd5, 32'h0000_00F4, 0, 0, 0, 0);
        check("to_100", pc, 32'h100);
        fetch(0, 32'h2222_2222); exec(3'd1, 32'hFFFF_FFF0, 0, 1, 0, 1);
        check("beq_taken", imem_addr, 32'hF0);
        fetch(0, 32'h3333_3333); exec(3'd5, 32'h0000_0010, 0, 0, 0, 0);
        fetch(1, 32'h4444_4444); exec(3'd1, 32'hFFFF_FFF0, 0, 0, 0, 0);
        check("beq_not", imem_addr, 32'h104);
        fetch(0, 32'h5555_5555); exec(3'd5, 32'h0000_00FC, 0, 0, 0, 0);
        fetch(0, 32'h6666_6666); exec(3'd6, 0, 32'h0000_1235, 0, 0, 2);
        check("jalr_pc", pc, 32'h1234);
        fetch(5, 32'h7777_7777); exec(3'd6, 0, 32'hFFFF_FFFC, 0, 0, 0);
        fetch(0, 32'h8888_8888); exec(3'd7, 32'h40, 0, 1, 1, 0);
        check("wrap_pc", pc, 32'h0);
        fetch(0, 32'h9999_9999); exec(3'd5, 32'h10, 0, 0, 0, 0);
        fetch(0, 32'hAAAA_AAAA); exec(3'd5, 32'h2, 0, 0, 0, 0);
        check("mis_halt", pc, 32'h10);
        halt_check(3);
        do_reset();
        imem_ack = 1'b0;
        @(negedge clk);
        do_reset();
        for (int it = 0; it < 250; it++) begin
            ri = ($urandom_range(0, 9) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            ra = ($urandom_range(0, 9) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFD);
            fetch($urandom_range(0, 3), $urandom);
            exec(3'($urandom), ri, ra, 1'($urandom), 1'($urandom), $urandom_range(0, 2));
            if (halted) begin
                halt_check(2);
                do_reset();
            end
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, address loaded into pc on reset.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 npc_op  input  3  next-PC select: SEQ=000, BEQ=001, BNE=010, BLT=011, BGE=100, JAL=101, JALR=110; 111 treated as SEQ.
REQ-005 imm  input  32  sign-extended branch/jump offset from the immediate generator.
REQ-006 alu_c  input  32  ALU result; JALR target base.
REQ-007 zero  input  1  ALU zero flag.
REQ-008 sgn  input  1  ALU result bit 31.
REQ-009 ex_valid  input  1  decode/ALU outputs for the held instruction are valid; commit strobe.
REQ-010 imem_req  output  1  instruction-memory read request.
REQ-011 imem_addr  output  32  instruction-memory read address.
REQ-012 imem_ack  input  1  read data valid this cycle.
REQ-013 imem_rdata  input  32  instruction word.
REQ-014 inst  output  32  held instruction to decode.
REQ-015 inst_valid  output  1  inst is valid and awaiting commit.
REQ-016 pc  output  32  address of held instruction.
REQ-017 pc4  output  32  pc + 4 (link value for JAL/JALR writeback).
REQ-018 misalign  output  1  sticky misaligned-target error.
REQ-019 instret  output  32  committed-instruction counter.

Function
REQ-020 FSM states SHALL be IDLE, FETCH, EXEC, HALT; outputs decoded from registered state only.
REQ-021 IDLE SHALL last exactly one cycle after reset release, then go to FETCH.
REQ-022 FETCH: imem_req=1, imem_addr=pc; on imem_ack, inst<=imem_rdata, go to EXEC; otherwise hold, with request and address stable.
REQ-023 imem_req SHALL be 0 and imem_addr SHALL equal pc in every state other than FETCH.
REQ-024 EXEC: inst_valid=1, inst and pc held; commit only when ex_valid=1, otherwise hold indefinitely.
REQ-025 On commit, the block SHALL compute npc as follows:
- SEQ: pc+4.
- BEQ: pc+imm if zero, else pc+4.
- BNE: pc+imm if !zero, else pc+4.
- BLT: pc+imm if sgn, else pc+4.
- BGE: pc+imm if !sgn, else pc+4.
- JAL: pc+imm.
- JALR: {alu_c[31:1],1'b0}.
REQ-026 All additions SHALL be 32-bit modulo 2^32; wrap-around is not an error.
REQ-027 BLT/BGE SHALL use sgn exactly as supplied; overflow correction is the upstream's responsibility.
REQ-028 Commit with npc[1:0]==00: pc<=npc, instret<=instret+1, go to FETCH.
REQ-029 Commit with npc[1:0]!=00: misalign<=1, pc unchanged, instret unchanged, go to HALT.
REQ-030 HALT SHALL persist until reset; imem_req=0, inst_valid=0.
REQ-031 instret SHALL wrap 32'hFFFF_FFFF -> 0.
REQ-032 imem_ack and ex_valid SHALL be ignored outside FETCH and EXEC respectively.
REQ-033 pc4 SHALL be combinational pc+4 at all times.
REQ-034 Minimum throughput SHALL be one instruction per 2 cycles (ack in the first FETCH cycle, ex_valid in the first EXEC cycle).

Reset
REQ-035 rst_n low SHALL immediately force state=IDLE, pc=RESET_PC, inst=0, inst_valid=0, imem_req=0, misalign=0, instret=0, from any state, including mid-FETCH with a request outstanding.
REQ-036 An imem_ack arriving while rst_n is low, or in the IDLE cycle, SHALL be discarded.

Verification
REQ-037 Reset release, imem_ack=1 every cycle, ex_valid=1, npc_op=SEQ -> imem_addr 0,4,8,... on alternate cycles; instret increments every 2 cycles.
REQ-038 pc=0x100, BEQ, imm=0xFFFF_FFF0, zero=1 -> next imem_addr=0xF0; same with zero=0 -> 0x104.
REQ-039 pc=0x200, JALR, alu_c=0x0000_1235 -> pc=0x1234; pc4 during EXEC=0x204.
REQ-040 pc=0x10, JAL, imm=0x2 -> misalign=1, HALT, pc stays 0x10, instret unchanged, imem_req stays 0.
REQ-041 imem_ack withheld 5 cycles -> imem_req/imem_addr stable for 5 cycles; inst captured on the ack cycle; pc=0xFFFF_FFFC SEQ commit -> pc=0.
REQ-042 rst_n pulsed low mid-FETCH and in HALT -> all outputs at reset values asynchronously; fetch restarts at RESET_PC after the IDLE cycle.
